mem_bus_bridge: RTL and testbench

- Bus master sitting directly upstream of the word-wide shared memory bus (mem_we / mem_addr / bidirectional mem_data) used by the on-chip RAM.
- Converts a core-side valid/ready request with byte enables into bus cycles.
- Full-word writes go out as a single write cycle; partial writes are done as read-modify-write, since the RAM has no byte lanes.
- Owns the mem_data tristate: drives it only while mem_we=1.

---
 rtl/mem_bus_bridge.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Core valid/ready to shared word-bus master; partial writes become read-modify-write.
// Optional address range check: define MEM_BRIDGE_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request, bus idle
// RD    | bus read, holds RD_WAIT extra cycles, samples mem_data on the last one
// WR    | single bus write cycle of data_q
// RSP   | one-cycle response pulse
module mem_bus_bridge #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] merged;
  logic        out_of_range;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

`ifdef MEM_BRIDGE_RANGE_CHECK_EN
  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
`else
  logic unused_depth;
  assign out_of_range = 1'b0;
  assign unused_depth = ^(32'(DEPTH_WORDS));
`endif

  // data_q holds the request's write data until the read lanes are merged in
  always_comb begin
    merged = mem_data;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    we_d        = we_q;
    be_d        = be_q;
    data_d      = data_q;
    wait_d      = wait_q;
    case (state_q)
      IDLE: begin
        ready_d    = 1'b1;
        mem_addr_d = '0;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          we_d    = req_we;
          be_d    = req_be;
          data_d  = req_wdata;
          wait_d  = WAIT_INIT;
          if (out_of_range) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_be == 4'h0) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
          end else if (req_we && req_be == 4'hF) begin
            state_d    = WR;
            mem_we_d   = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end else begin
            state_d    = RD;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      RD: begin
        if (wait_q == 4'd0) begin
          if (we_q) begin
            data_d   = merged;
            state_d  = WR;
            mem_we_d = 1'b1;
          end else begin
            data_d      = mem_data;
            rsp_rdata_d = mem_data;
            rsp_valid_d = 1'b1;
            mem_addr_d  = '0;
            state_d     = RSP;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        mem_addr_d  = '0;
      end
      RSP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      data_q      <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_we_q ? data_q : 'z;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: vector table against a RAM model, plus reset-in-WR
// and RD_WAIT=3 sequences on a second instance.
module tb_mem_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_addr;
  wire  [31:0] mem_data;

  logic        req_ready2, rsp_valid2, rsp_err2, mem_we2;
  logic [31:0] rsp_rdata2, mem_addr2;
  wire  [31:0] mem_data2;

  mem_bus_bridge #(.DEPTH_WORDS(1024), .RD_WAIT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  mem_bus_bridge #(.DEPTH_WORDS(1024), .RD_WAIT(3)) dut_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_data(mem_data2)
  );

  // RAM behind the first bridge: drives the bus whenever the bridge is not writing
  logic [31:0] ram [0:1023] = '{default: 32'h0};
  assign mem_data = mem_we ? 32'bz : ram[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we && mem_addr[31:12] == 20'h0) ram[mem_addr[11:2]] <= mem_data;
  end

  // Second bus: address-dependent constant pattern, writes only observed
  assign mem_data2 = mem_we2 ? 32'bz : (32'h1234_5678 ^ mem_addr2);

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr_cnt;
    logic [31:0] wr_word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input int lat, input logic [31:0] rdata,
                              input logic err, input int wr_cnt, input logic [31:0] wr_word);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.lat = lat;
    v.rdata = rdata; v.err = err; v.wr_cnt = wr_cnt; v.wr_word = wr_word;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input int idx, input vec_t v);
    int lat;
    int wr_cnt;
    bit seen;
    int tmo;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    req_valid = 1'b1;
    tmo = 0;
    while (!req_ready && tmo < 20) begin
      step();
      tmo++;
    end
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1; wr_cnt = 0; seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (mem_we) begin
        wr_cnt++;
        chk($sformatf("v%0d_wr_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_wr_data", idx), mem_data, v.wr_word);
      end
      if (rsp_valid) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    chk($sformatf("v%0d_rsp_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("v%0d_wr_cnt", idx), 32'(wr_cnt), 32'(v.wr_cnt));
    chk($sformatf("v%0d_busy_ready", idx), 32'(req_ready), 32'd0);
    step();
    chk($sformatf("v%0d_pulse_end", idx), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d_ready_back", idx), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d_addr_idle", idx), mem_addr, 32'h0);
  endtask

  task automatic run_req2(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                          input logic [31:0] exp_rdata, input int exp_wr, input logic [31:0] exp_word);
    int lat;
    int wr_cnt;
    int tmo;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid2 = 1'b1;
    tmo = 0;
    while (!req_ready2 && tmo < 20) begin
      step();
      tmo++;
    end
    chk({nm, "_ready"}, 32'(req_ready2), 32'd1);
    step();
    req_valid2 = 1'b0;
    lat = 1; wr_cnt = 0;
    while (!rsp_valid2 && lat <= 40) begin
      if (mem_we2) begin
        wr_cnt++;
        chk({nm, "_wr_data"}, mem_data2, exp_word);
        chk({nm, "_wr_addr"}, mem_addr2, {addr[31:2], 2'b00});
      end
      step();
      lat++;
    end
    chk({nm, "_rsp_seen"}, 32'(rsp_valid2), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rdata"}, rsp_rdata2, exp_rdata);
    chk({nm, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
    chk({nm, "_err"}, 32'(rsp_err2), 32'd0);
    step();
  endtask

  initial begin
    vecs.push_back(mk(1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 2, 32'h0,         1'b0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDEAD_BEEF, 1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h10,  32'h0000_AA00, 4'h2, 3, 32'h0,         1'b0, 1, 32'hDEAD_AAEF));
    vecs.push_back(mk(1'b0, 32'h10,  32'h0,         4'hF, 2, 32'hDEAD_AAEF, 1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h10,  32'hFFFF_FFFF, 4'h0, 1, 32'h0,         1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h10,  32'h0,         4'h0, 2, 32'hDEAD_AAEF, 1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h20,  32'h1122_3344, 4'h9, 3, 32'h0,         1'b0, 1, 32'h1100_0044));
    vecs.push_back(mk(1'b0, 32'h20,  32'h0,         4'h0, 2, 32'h1100_0044, 1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 32'hFFC, 32'hA5A5_A5A5, 4'hF, 2, 32'h0,         1'b0, 1, 32'hA5A5_A5A5));
    vecs.push_back(mk(1'b0, 32'hFFF, 32'h0,         4'h0, 2, 32'hA5A5_A5A5, 1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h13,  32'h0,         4'h0, 2, 32'hDEAD_AAEF, 1'b0, 0, 32'h0));
`ifdef MEM_BRIDGE_RANGE_CHECK_EN
    vecs.push_back(mk(1'b0, 32'h1000, 32'h0,         4'h0, 1, 32'h0,         1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h2000, 32'h5555_5555, 4'hF, 1, 32'h0,         1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 32'hFFC,  32'h0,         4'h0, 2, 32'hA5A5_A5A5, 1'b0, 0, 32'h0));
`endif

    rst = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_bus_released", mem_data, ram[0]);
    chk("rst_req_ready2", 32'(req_ready2), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_ready_pre_edge", 32'(req_ready), 32'd0);
    step();
    chk("release_ready_after_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_req(i, vecs[i]);

    // Reset while the bridge is in its write cycle: no RAM update, no response
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_be = 4'hF;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("midrst_in_wr", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_we_drop", 32'(mem_we), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_ram_kept", ram[4], 32'hDEAD_AAEF);
    rst = 1'b1;
    step();
    chk("midrst_no_rsp_after", 32'(rsp_valid), 32'd0);
    run_req(100, mk(1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEAD_AAEF, 1'b0, 0, 32'h0));

    // RD_WAIT=3 instance: read adds three cycles, partial write likewise
    run_req2("w3_read", 1'b0, 32'h40, 32'h0, 4'h0, 5, 32'h1234_5678 ^ 32'h40, 0, 32'h0);
    run_req2("w3_pwrite", 1'b1, 32'h80, 32'h00CC_0000, 4'h4, 6, 32'h0, 1, 32'h12CC_56F8);
    run_req2("w3_fwrite", 1'b1, 32'h84, 32'hCAFE_F00D, 4'hF, 2, 32'h0, 1, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
